// File: rtl/lm32_dp_ram.sv
// lm32_dp_ram: simple dual-port RAM with registered read address and write-first reads
module lm32_dp_ram #(
  parameter int data_width    = 1,
  parameter int address_width = 1
) (
  input  logic                     read_clk,
  input  logic                     write_clk,
  input  logic                     reset,
  input  logic [address_width-1:0] read_address,
  input  logic                     enable_read,
  input  logic [address_width-1:0] write_address,
  input  logic                     enable_write,
  input  logic                     write_enable,
  input  logic [data_width-1:0]    write_data,
  output logic [data_width-1:0]    read_data
);
  logic [data_width-1:0]    mem [0:2**address_width-1] = '{default: '0};
  logic [address_width-1:0] ra;
  always_ff @(posedge write_clk)
    if (enable_write && write_enable) mem[write_address] <= write_data;
  always_ff @(posedge read_clk)
    ra <= reset ? '0 : enable_read ? read_address : ra;
  assign read_data = mem[ra];
endmodule

// File: tb/tb_lm32_dp_ram.sv
// tb_lm32_dp_ram: scoreboard bench for lm32_dp_ram in an 8x16 and a 41x1024 configuration
module tb_lm32_dp_ram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       a_rst, a_er, a_ew, a_we;
  logic [3:0] a_ra, a_wa;
  logic [7:0] a_wd, a_rd;
  logic        b_rst, b_er, b_ew, b_we;
  logic [9:0]  b_ra, b_wa;
  logic [40:0] b_wd, b_rd;
  lm32_dp_ram #(.data_width(8), .address_width(4)) dut_a (
    .read_clk(clk), .write_clk(clk), .reset(a_rst),
    .read_address(a_ra), .enable_read(a_er),
    .write_address(a_wa), .enable_write(a_ew), .write_enable(a_we),
    .write_data(a_wd), .read_data(a_rd)
  );
  lm32_dp_ram #(.data_width(41), .address_width(10)) dut_b (
    .read_clk(clk), .write_clk(clk), .reset(b_rst),
    .read_address(b_ra), .enable_read(b_er),
    .write_address(b_wa), .enable_write(b_ew), .write_enable(b_we),
    .write_data(b_wd), .read_data(b_rd)
  );
  typedef struct {
    int          cyc;
    bit          wide;
    logic [40:0] exp;
    string       name;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [40:0] act;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = e.wide ? b_rd : {33'b0, a_rd};
      checks++;
      if (act !== e.exp) $display("FAIL %s: read_data=%h expected=%h", e.name, act, e.exp);
      else passed++;
    end
  task automatic a_step(input logic rst, input logic er, input logic [3:0] ra,
                        input logic ew, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input bit chk, input logic [7:0] exp,
                        input string name);
    a_rst = rst; a_er = er; a_ra = ra; a_ew = ew; a_we = we; a_wa = wa; a_wd = wd;
    if (chk) q.push_back('{cyc + 1, 1'b0, {33'b0, exp}, name});
    @(posedge clk);
    #1;
  endtask
  task automatic b_step(input logic rst, input logic er, input logic [9:0] ra,
                        input logic ew, input logic we, input logic [9:0] wa,
                        input logic [40:0] wd, input bit chk, input logic [40:0] exp,
                        input string name);
    b_rst = rst; b_er = er; b_ra = ra; b_ew = ew; b_we = we; b_wa = wa; b_wd = wd;
    if (chk) q.push_back('{cyc + 1, 1'b1, exp, name});
    @(posedge clk);
    #1;
  endtask
  localparam logic [40:0] W1 = {1'b1, 40'h12345_6789A};
  localparam logic [40:0] W2 = 41'h0_A5A5A_5A5A5;
  initial begin
    b_rst = 1'b0; b_er = 1'b0; b_ra = '0; b_ew = 1'b0; b_we = 1'b0; b_wa = '0; b_wd = '0;
    a_step(1, 1, 4'd5,  0, 0, 4'd0,  8'h00, 1, 8'h00, "rst_edge1");
    a_step(1, 1, 4'd5,  0, 0, 4'd0,  8'h00, 1, 8'h00, "rst_edge2");
    a_step(0, 1, 4'd5,  0, 0, 4'd0,  8'h00, 1, 8'h00, "init_rd5");
    a_step(0, 0, 4'd0,  1, 1, 4'd3,  8'hA5, 1, 8'h00, "hold5_wr3");
    a_step(0, 0, 4'd0,  1, 1, 4'd15, 8'h3C, 0, 8'h00, "");
    a_step(0, 1, 4'd3,  0, 0, 4'd0,  8'h00, 1, 8'hA5, "rd3");
    a_step(0, 1, 4'd15, 0, 0, 4'd0,  8'h00, 1, 8'h3C, "rd15");
    a_step(0, 1, 4'd3,  0, 1, 4'd3,  8'hFF, 1, 8'hA5, "gate_ew");
    a_step(0, 0, 4'd15, 0, 0, 4'd0,  8'h00, 1, 8'hA5, "gate_er");
    a_step(0, 1, 4'd7,  1, 1, 4'd7,  8'h77, 1, 8'h77, "collide");
    a_step(0, 1, 4'd7,  1, 1, 4'd9,  8'h5A, 1, 8'h77, "indep");
    a_step(0, 1, 4'd9,  0, 0, 4'd0,  8'h00, 1, 8'h5A, "rd9");
    a_step(0, 1, 4'd3,  0, 0, 4'd0,  8'h00, 1, 8'hA5, "cap3");
    a_step(0, 0, 4'd9,  1, 1, 4'd3,  8'h11, 1, 8'h11, "held_upd");
    a_step(1, 1, 4'd7,  0, 0, 4'd0,  8'h00, 1, 8'h00, "rst_prio");
    a_step(0, 1, 4'd15, 0, 0, 4'd0,  8'h00, 1, 8'h3C, "post_rst15");
    a_step(0, 0, 4'd0,  0, 0, 4'd0,  8'h00, 0, 8'h00, "");
    b_step(1, 1, 10'd5,    1, 1, 10'd0,    W1, 1, W1, "b_rst_wr0");
    b_step(0, 0, 10'd0,    1, 1, 10'd1023, W2, 1, W1, "b_hold0");
    b_step(0, 1, 10'd1023, 0, 0, 10'd0,    '0, 1, W2, "b_rd1023");
    b_step(0, 1, 10'd0,    0, 0, 10'd0,    '0, 1, W1, "b_rd0");
    b_step(0, 1, 10'd1022, 0, 0, 10'd0,    '0, 1, '0, "b_rd1022");
    b_step(0, 1, 10'd1,    0, 0, 10'd0,    '0, 1, '0, "b_rd1");
    b_step(0, 0, 10'd0,    0, 0, 10'd0,    '0, 0, '0, "");
    repeat (3) @(posedge clk);
    #1;
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      $display("FAIL %s: never checked, expected=%h", e.name, e.exp);
    end
    checks++;
    if (a_rd !== 8'h3C) $display("FAIL a_held15: read_data=%h expected=3c", a_rd);
    else passed++;
    checks++;
    if (b_rd !== 41'h0) $display("FAIL b_held1: read_data=%h expected=0", b_rd);
    else passed++;
    b_er = 1'b1; b_ra = 10'd1023;
    @(posedge clk);
    #1;
    b_er = 1'b0;
    checks++;
    if (b_rd !== W2) $display("FAIL b_final1023: read_data=%h expected=%h", b_rd, W2);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
